id_ex_reg: RTL and testbench
============================

// Module: id_ex_reg
// PURPOSE
//   ID/EX pipeline register of the 5-stage MIPS pipeline. Captures decoded control
//   (WB/M/EX groups), register-file read data, sign-extended immediate and the
//   rs/rt/rd indices at the end of ID. Its outputs drive the EX stage and the forwarding
//   unit's Rs/Rt compare inputs. Supports stall (hold), flush (bubble) and a valid bit.
// PARAMETERS
//   DW      32   datapath width (read data, immediate)
//   RW      5    register index width
// PORTS
//   clk_i          in   1    clock, rising edge
//   rst_i          in   1    asynchronous, active-high reset
//   stall_i        in   1    hold all stored fields this cycle
//   flush_i        in   1    load a bubble this cycle
//   WB_i           in   2    {RegWrite, MemtoReg} from ID decode
//   M_i            in   2    {MemRead, MemWrite}
//   EX_i           in   4    {RegDst, ALUOp[1:0], ALUSrc}
//   RSdata_i       in   DW   register-file read data, port 1
//   RTdata_i       in   DW   register-file read data, port 2
//   imm_i          in   DW   sign-extended immediate
//   inst25_21_i    in   RW   rs index
//   inst20_16_i    in   RW   rt index
//   inst15_11_i    in   RW   rd index
//   wb_we_i        in   1    MEM/WB RegWrite (used only with bypass)
//   wb_rd_i        in   RW   MEM/WB destination index (used only with bypass)
//   wb_data_i      in   DW   MEM/WB write data (used only with bypass)
//   WB_o/M_o/EX_o  out  2/2/4 registered control groups
//   RSdata_o, RTdata_o, imm_o          out DW  registered data
//   inst25_21_o, inst20_16_o, inst15_11_o out RW registered indices
//   valid_o        out  1    1 = stage holds a real instruction
// BEHAVIOUR
//   - Reset (async, rst_i=1): every output 0, valid_o=0; state leaves reset on the
//     first rising edge after rst_i deasserts. Reset mid-stall/flush: reset wins.
//   - Priority per rising edge: rst_i > flush_i > stall_i > load.
//   - Load (flush_i=0, stall_i=0): all *_o <= corresponding *_i, valid_o <= 1. Latency 1.
//   - Flush: WB_o, M_o, EX_o, all data and index fields <= 0, valid_o <= 0. Zeroed
//     indices guarantee no forwarding match (rs=rt=0). flush_i+stall_i together = bubble.
//   - Stall: all fields hold; valid_o holds. Held bubble remains a bubble.
//   - No combinational path from any input to any output.
//   - Control groups pass unmodified; no decode is performed here.
// CONFIGURATION
//   ID_EX_WB_BYPASS_EN defined:
//     - Load: if wb_we_i && wb_rd_i!=0 && wb_rd_i==inst25_21_i, RSdata_o <= wb_data_i
//       instead of RSdata_i; same for rt/RTdata. Covers same-cycle regfile write/read.
//     - Stall: if wb_we_i && wb_rd_i!=0 && wb_rd_i==held inst25_21_o, RSdata_o <=
//       wb_data_i (rt likewise); all other fields hold. Not applied during flush.
//     - wb_rd_i==0 never bypasses.
//   Not defined: wb_* inputs ignored; RSdata_o/RTdata_o come only from RSdata_i/RTdata_i.
// TESTING
//   1 rst_i=1 mid-cycle with inputs nonzero -> all outputs 0 immediately, valid_o=0.
//   2 load WB_i=2'b10, EX_i=4'b1100, rs=3, rt=4, rd=5, RSdata_i=32'hA5 -> next edge
//     outputs match, valid_o=1; inputs change with stall_i=1 -> outputs unchanged 3 edges.
//   3 flush_i=1, stall_i=1 with valid inputs -> next edge all fields 0, valid_o=0;
//     then stall_i=1 alone -> bubble held.
//   4 (BYPASS_EN) load rs=7, RSdata_i=1, wb_we_i=1, wb_rd_i=7, wb_data_i=32'h55 ->
//     RSdata_o=32'h55; repeat with wb_rd_i=0, rs=0 -> RSdata_o=RSdata_i.
//   5 (BYPASS_EN) holding rt=9 under stall, wb_we_i=1, wb_rd_i=9, wb_data_i=32'h77 ->
//     RTdata_o=32'h77, all other outputs unchanged; without macro -> RTdata_o unchanged.
//   6 back-to-back loads of 3 distinct instructions -> each appears exactly one edge later.

Source files
------------

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register of the 5-stage MIPS pipeline.
// Captures decoded control groups (WB/M/EX), register-file read data, the
// sign-extended immediate and the rs/rt/rd indices at the end of ID, plus a
// valid bit.
//
// Optional feature macro: ID_EX_WB_BYPASS_EN
//   When defined, a MEM/WB register write that targets rs or rt in the same
//   cycle overrides the stale regfile read data. This happens on load, and
//   also on stall against the held indices. Index 0 never bypasses, and a
//   flush never bypasses. When undefined, the wb_* inputs are ignored.
//
// Control semantics (one rising edge, highest priority first):
//   rst_i   : async clear of every field; valid_o = 0
//   flush_i : load a bubble (all fields 0, valid_o = 0), even if stall_i = 1
//   stall_i : hold every field and valid_o (bypass may refresh rs/rt data)
//   neither : load every *_i into *_o, valid_o = 1
// All outputs come straight from flops; there is no input-to-output comb path.
module id_ex_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [1:0]    WB_i,
  input  logic [1:0]    M_i,
  input  logic [3:0]    EX_i,
  input  logic [DW-1:0] RSdata_i,
  input  logic [DW-1:0] RTdata_i,
  input  logic [DW-1:0] imm_i,
  input  logic [RW-1:0] inst25_21_i,
  input  logic [RW-1:0] inst20_16_i,
  input  logic [RW-1:0] inst15_11_i,
  input  logic          wb_we_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [1:0]    WB_o,
  output logic [1:0]    M_o,
  output logic [3:0]    EX_o,
  output logic [DW-1:0] RSdata_o,
  output logic [DW-1:0] RTdata_o,
  output logic [DW-1:0] imm_o,
  output logic [RW-1:0] inst25_21_o,
  output logic [RW-1:0] inst20_16_o,
  output logic [RW-1:0] inst15_11_o,
  output logic          valid_o
);

  logic [1:0]    wb_q, wb_d;
  logic [1:0]    m_q, m_d;
  logic [3:0]    ex_q, ex_d;
  logic [DW-1:0] rsdata_q, rsdata_d;
  logic [DW-1:0] rtdata_q, rtdata_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          valid_q, valid_d;

  // Data chosen for rs/rt on a load and on a stall.
  logic [DW-1:0] rs_load_data, rt_load_data;
  logic [DW-1:0] rs_stall_data, rt_stall_data;

`ifdef ID_EX_WB_BYPASS_EN
  logic wb_live;
  assign wb_live = wb_we_i && (wb_rd_i != '0);

  // Load compares against the incoming indices.
  assign rs_load_data  = (wb_live && (wb_rd_i == inst25_21_i)) ? wb_data_i : RSdata_i;
  assign rt_load_data  = (wb_live && (wb_rd_i == inst20_16_i)) ? wb_data_i : RTdata_i;
  // Stall compares against the indices already held in the register.
  assign rs_stall_data = (wb_live && (wb_rd_i == rs_q)) ? wb_data_i : rsdata_q;
  assign rt_stall_data = (wb_live && (wb_rd_i == rt_q)) ? wb_data_i : rtdata_q;
`else
  assign rs_load_data  = RSdata_i;
  assign rt_load_data  = RTdata_i;
  assign rs_stall_data = rsdata_q;
  assign rt_stall_data = rtdata_q;

  logic unused_wb;
  assign unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

  // Next-state selection: flush beats stall beats load.
  always_comb begin
    wb_d     = wb_q;
    m_d      = m_q;
    ex_d     = ex_q;
    rsdata_d = rsdata_q;
    rtdata_d = rtdata_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    if (flush_i) begin
      wb_d     = '0;
      m_d      = '0;
      ex_d     = '0;
      rsdata_d = '0;
      rtdata_d = '0;
      imm_d    = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      valid_d  = 1'b0;
    end else if (stall_i) begin
      rsdata_d = rs_stall_data;
      rtdata_d = rt_stall_data;
    end else begin
      wb_d     = WB_i;
      m_d      = M_i;
      ex_d     = EX_i;
      rsdata_d = rs_load_data;
      rtdata_d = rt_load_data;
      imm_d    = imm_i;
      rs_d     = inst25_21_i;
      rt_d     = inst20_16_i;
      rd_d     = inst15_11_i;
      valid_d  = 1'b1;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q     <= '0;
      m_q      <= '0;
      ex_q     <= '0;
      rsdata_q <= '0;
      rtdata_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      ex_q     <= ex_d;
      rsdata_q <= rsdata_d;
      rtdata_q <= rtdata_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
    end
  end

  assign WB_o        = wb_q;
  assign M_o         = m_q;
  assign EX_o        = ex_q;
  assign RSdata_o    = rsdata_q;
  assign RTdata_o    = rtdata_q;
  assign imm_o       = imm_q;
  assign inst25_21_o = rs_q;
  assign inst20_16_o = rt_q;
  assign inst15_11_o = rd_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: self-checking bench for id_ex_reg. A record-level reference
// model runs alongside the DUT and is compared on every falling edge; directed
// literal checks pin the model to hand-computed values.
module tb_id_ex_reg;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic [1:0]    wb;
    logic [1:0]    m;
    logic [3:0]    ex;
    logic [DW-1:0] rsd;
    logic [DW-1:0] rtd;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          valid;
  } rec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          stall, flush;
  logic [1:0]    wb_i, m_i;
  logic [3:0]    ex_i;
  logic [DW-1:0] rsd_i, rtd_i, imm_i;
  logic [RW-1:0] rs_i, rt_i, rd_i;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  logic [1:0]    WB_o, M_o;
  logic [3:0]    EX_o;
  logic [DW-1:0] RSdata_o, RTdata_o, imm_o;
  logic [RW-1:0] inst25_21_o, inst20_16_o, inst15_11_o;
  logic          valid_o;

  id_ex_reg #(.DW(DW), .RW(RW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .WB_i(wb_i), .M_i(m_i), .EX_i(ex_i),
    .RSdata_i(rsd_i), .RTdata_i(rtd_i), .imm_i(imm_i),
    .inst25_21_i(rs_i), .inst20_16_i(rt_i), .inst15_11_i(rd_i),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .WB_o(WB_o), .M_o(M_o), .EX_o(EX_o),
    .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .imm_o(imm_o),
    .inst25_21_o(inst25_21_o), .inst20_16_o(inst20_16_o), .inst15_11_o(inst15_11_o),
    .valid_o(valid_o)
  );

  rec_t dut_rec;
  assign dut_rec = '{WB_o, M_o, EX_o, RSdata_o, RTdata_o, imm_o,
                     inst25_21_o, inst20_16_o, inst15_11_o, valid_o};

  // ---------------- reference model ----------------
  rec_t exp_rec;
  rec_t in_rec;
  assign in_rec = '{wb_i, m_i, ex_i, rsd_i, rtd_i, imm_i, rs_i, rt_i, rd_i, 1'b1};

  function automatic logic bypass_hit(logic [RW-1:0] idx);
`ifdef ID_EX_WB_BYPASS_EN
    return wb_we && (wb_rd != 0) && (wb_rd == idx);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) exp_rec <= '0;
    else if (flush) exp_rec <= '0;
    else if (stall) begin
      rec_t h;
      h = exp_rec;
      if (bypass_hit(h.rs)) h.rsd = wb_data;
      if (bypass_hit(h.rt)) h.rtd = wb_data;
      exp_rec <= h;
    end else begin
      rec_t n;
      n = in_rec;
      if (bypass_hit(n.rs)) n.rsd = wb_data;
      if (bypass_hit(n.rt)) n.rtd = wb_data;
      exp_rec <= n;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_rec !== exp_rec) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, dut_rec, exp_rec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] w, input logic [1:0] m, input logic [3:0] e,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] im,
                       input logic [RW-1:0] s, input logic [RW-1:0] t, input logic [RW-1:0] d);
    wb_i = w; m_i = m; ex_i = e; rsd_i = a; rtd_i = b; imm_i = im;
    rs_i = s; rt_i = t; rd_i = d;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drive(2'b00, 2'b00, 4'h0, '0, '0, '0, '0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_valid", 128'(valid_o), 128'(0));
    chk("reset_all", 128'(dut_rec), 128'(0));

    // 1: async reset mid-cycle with nonzero inputs and state.
    drive(2'b11, 2'b01, 4'b1010, 32'h1111, 32'h2222, 32'h3333, 5'd1, 5'd2, 5'd3);
    tick();
    chk("t1_load_rs", 128'(RSdata_o), 128'(32'h1111));
    chk("t1_load_valid", 128'(valid_o), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("t1_async_all", 128'(dut_rec), 128'(0));
    chk("t1_async_valid", 128'(valid_o), 128'(0));
    tick();
    rst = 1'b0;

    // 2: load then stall for three edges with changing inputs.
    drive(2'b10, 2'b00, 4'b1100, 32'hA5, 32'h5A, 32'hFFFF_FFF0, 5'd3, 5'd4, 5'd5);
    tick();
    chk("t2_wb", 128'(WB_o), 128'(2'b10));
    chk("t2_ex", 128'(EX_o), 128'(4'b1100));
    chk("t2_rs_idx", 128'(inst25_21_o), 128'(3));
    chk("t2_rt_idx", 128'(inst20_16_o), 128'(4));
    chk("t2_rd_idx", 128'(inst15_11_o), 128'(5));
    chk("t2_rsdata", 128'(RSdata_o), 128'(32'hA5));
    chk("t2_valid", 128'(valid_o), 128'(1));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 2'b11, 4'b0011, 32'h100 + i, 32'h200 + i, 32'h300 + i, 5'd10, 5'd11, 5'd12);
      tick();
      chk("t2_stall_rs", 128'(RSdata_o), 128'(32'hA5));
      chk("t2_stall_ex", 128'(EX_o), 128'(4'b1100));
    end

    // 3: flush+stall gives a bubble; stall alone keeps it.
    flush = 1'b1;
    tick();
    chk("t3_bubble_all", 128'(dut_rec), 128'(0));
    chk("t3_bubble_valid", 128'(valid_o), 128'(0));
    flush = 1'b0;
    tick(); tick();
    chk("t3_bubble_held", 128'(dut_rec), 128'(0));
    stall = 1'b0;

    // 4: load-time bypass on rs; wb_rd == 0 never bypasses.
    drive(2'b10, 2'b00, 4'b0000, 32'h1, 32'h2, 32'h0, 5'd7, 5'd6, 5'd1);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    tick();
`ifdef ID_EX_WB_BYPASS_EN
    chk("t4_bypass_rs", 128'(RSdata_o), 128'(32'h55));
`else
    chk("t4_bypass_rs", 128'(RSdata_o), 128'(32'h1));
`endif
    chk("t4_rt_untouched", 128'(RTdata_o), 128'(32'h2));
    wb_rd = 5'd0; rs_i = 5'd0;
    tick();
    chk("t4_zero_rd", 128'(RSdata_o), 128'(32'h1));
    wb_we = 1'b0;

    // 5: stall-time bypass on held rt.
    drive(2'b11, 2'b10, 4'b0101, 32'h88, 32'h99, 32'h44, 5'd8, 5'd9, 5'd2);
    tick();
    stall = 1'b1;
    drive(2'b00, 2'b00, 4'b0000, 32'hDEAD, 32'hBEEF, 32'h0, 5'd9, 5'd9, 5'd9);
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h77;
    tick();
`ifdef ID_EX_WB_BYPASS_EN
    chk("t5_stall_rt", 128'(RTdata_o), 128'(32'h77));
`else
    chk("t5_stall_rt", 128'(RTdata_o), 128'(32'h99));
`endif
    chk("t5_stall_rs", 128'(RSdata_o), 128'(32'h88));
    chk("t5_stall_imm", 128'(imm_o), 128'(32'h44));
    chk("t5_stall_rt_idx", 128'(inst20_16_o), 128'(9));
    stall = 1'b0; wb_we = 1'b0;

    // 6: three back-to-back loads, each visible one edge later.
    for (int i = 0; i < 3; i++) begin
      drive(2'(i), 2'(i + 1), 4'(i + 4), 32'hC0DE_0000 + i, 32'h10 + i, 32'h20 + i,
            5'(i + 1), 5'(i + 2), 5'(i + 3));
      exp_q.push_back(32'hC0DE_0000 + i);
      tick();
      chk("t6_b2b_rs", 128'(RSdata_o), 128'(exp_q.pop_front()));
      chk("t6_b2b_rd_idx", 128'(inst15_11_o), 128'(i + 3));
    end

    // Mixed traffic against the model only.
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom, $urandom, $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      wb_we = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      tick();
    end
    stall = 1'b0; flush = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
